async_sram_ctrl_ahb: RTL and testbench

// AHB-Lite slave (32-bit data) driving a 16-bit asynchronous SRAM via async_sram_phy.

---
 rtl/async_sram_ctrl_ahb.sv | 178 +++++++++++++++++
 tb/tb_async_sram_ctrl_ahb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_sram_ctrl_ahb.sv
// AHB-Lite slave bridging 32-bit bus transfers onto a 16-bit asynchronous SRAM PHY.
// Words take two halfword SRAM cycles; halves/bytes take one. Wait states come from hready_resp.
module async_sram_ctrl_ahb #(
    parameter int W_ADDR = 18,
    parameter int W_DATA = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [31:0]       ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [31:0]       ahbls_hwdata,
    output logic [31:0]       ahbls_hrdata,
    output logic [W_ADDR-1:0] ctrl_addr,
    output logic [W_DATA-1:0] ctrl_dq_out,
    output logic [W_DATA-1:0] ctrl_dq_oe,
    input  logic [W_DATA-1:0] ctrl_dq_in,
    output logic              ctrl_ce_n,
    output logic              ctrl_we_n,
    output logic              ctrl_oe_n,
    output logic [1:0]        ctrl_byte_n
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, WR_LO, WR_HI, WR_TAIL
    } state_e;

    state_e            state_q, state_d;
    logic [W_ADDR:1]   addr_q, addr_d;
    logic              word_q, word_d;
    logic [W_DATA-1:0] wbuf_q, wbuf_d;
    logic [W_DATA-1:0] rd_lo_q, rd_lo_d;
    logic              rd_done_q, rd_done_d;
    logic              hready_resp_q, hready_resp_d;
    logic [W_ADDR-1:0] ctrl_addr_q, ctrl_addr_d;
    logic [W_DATA-1:0] dq_out_q, dq_out_d;
    logic [W_DATA-1:0] dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic [1:0]        byte_n_q, byte_n_d;

    logic accept;
    logic word_in;
    logic unused_bits;

    assign accept      = ahbls_hready & ahbls_htrans[1];
    assign word_in     = (ahbls_hsize == 3'd2);
    assign unused_bits = ^{ahbls_haddr[31:W_ADDR+1], ahbls_htrans[0]};

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        word_d        = word_q;
        wbuf_d        = wbuf_q;
        rd_lo_d       = rd_lo_q;
        rd_done_d     = 1'b0;
        hready_resp_d = 1'b1;
        ctrl_addr_d   = '0;
        dq_out_d      = '0;
        dq_oe_d       = '0;
        ce_n_d        = 1'b1;
        we_n_d        = 1'b1;
        oe_n_d        = 1'b1;
        byte_n_d      = 2'b11;

        unique case (state_q)
            IDLE, WR_TAIL: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d        = ahbls_haddr[W_ADDR:1];
                    word_d        = word_in;
                    hready_resp_d = 1'b0;
                    ce_n_d        = 1'b0;
                    ctrl_addr_d   = word_in ? {ahbls_haddr[W_ADDR:2], 1'b0} : ahbls_haddr[W_ADDR:1];
                    if (ahbls_hwrite) begin
                        we_n_d   = 1'b0;
                        byte_n_d = (ahbls_hsize == 3'd0) ? (ahbls_haddr[0] ? 2'b01 : 2'b10) : 2'b00;
                        state_d  = word_in ? WR_LO : WR_HI;
                    end else begin
                        oe_n_d   = 1'b0;
                        byte_n_d = 2'b00;
                        state_d  = word_in ? RD_LO : RD_HI;
                    end
                end
            end
            RD_LO: begin
                state_d       = RD_HI;
                hready_resp_d = 1'b0;
                ctrl_addr_d   = {addr_q[W_ADDR:2], 1'b1};
                ce_n_d        = 1'b0;
                oe_n_d        = 1'b0;
                byte_n_d      = 2'b00;
            end
            RD_HI: begin
                // Pad data for the low half arrives now; the high half is live on dq_in next cycle.
                state_d   = IDLE;
                rd_lo_d   = ctrl_dq_in;
                rd_done_d = 1'b1;
            end
            WR_LO: begin
                state_d       = WR_HI;
                hready_resp_d = 1'b0;
                wbuf_d        = ahbls_hwdata[31:16];
                ctrl_addr_d   = {addr_q[W_ADDR:2], 1'b1};
                ce_n_d        = 1'b0;
                we_n_d        = 1'b0;
                byte_n_d      = 2'b00;
                dq_out_d      = ahbls_hwdata[15:0];
                dq_oe_d       = '1;
            end
            WR_HI: begin
                // Data trails the strobe by one cycle because the PHY delays we_n but not dq.
                state_d     = WR_TAIL;
                ctrl_addr_d = ctrl_addr_q;
                dq_oe_d     = '1;
                if (word_q) begin
                    dq_out_d = wbuf_q;
                end else begin
                    dq_out_d = addr_q[1] ? ahbls_hwdata[31:16] : ahbls_hwdata[15:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            word_q        <= 1'b0;
            wbuf_q        <= '0;
            rd_lo_q       <= '0;
            rd_done_q     <= 1'b0;
            hready_resp_q <= 1'b1;
            ctrl_addr_q   <= '0;
            dq_out_q      <= '0;
            dq_oe_q       <= '0;
            ce_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            byte_n_q      <= 2'b11;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            word_q        <= word_d;
            wbuf_q        <= wbuf_d;
            rd_lo_q       <= rd_lo_d;
            rd_done_q     <= rd_done_d;
            hready_resp_q <= hready_resp_d;
            ctrl_addr_q   <= ctrl_addr_d;
            dq_out_q      <= dq_out_d;
            dq_oe_q       <= dq_oe_d;
            ce_n_q        <= ce_n_d;
            we_n_q        <= we_n_d;
            oe_n_q        <= oe_n_d;
            byte_n_q      <= byte_n_d;
        end
    end

    assign ahbls_hready_resp = hready_resp_q;
    assign ahbls_hresp       = 1'b0;
    assign ahbls_hrdata      = rd_done_q ? (word_q ? {ctrl_dq_in, rd_lo_q} : {2{ctrl_dq_in}}) : 32'h0;
    assign ctrl_addr         = ctrl_addr_q;
    assign ctrl_dq_out       = dq_out_q;
    assign ctrl_dq_oe        = dq_oe_q;
    assign ctrl_ce_n         = ce_n_q;
    assign ctrl_we_n         = we_n_q;
    assign ctrl_oe_n         = oe_n_q;
    assign ctrl_byte_n       = byte_n_q;

endmodule

// File: tb/tb_async_sram_ctrl_ahb.sv
// Bench for async_sram_ctrl_ahb: pipelined AHB driver, PHY+SRAM pin model, byte-level reference memory.
module tb_async_sram_ctrl_ahb;

    localparam int W_ADDR = 18;
    localparam logic [31:0] ADDR_MASK = 32'h0007_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              ahbls_hready;
    logic              ahbls_hready_resp;
    logic              ahbls_hresp;
    logic [31:0]       ahbls_haddr;
    logic              ahbls_hwrite;
    logic [1:0]        ahbls_htrans;
    logic [2:0]        ahbls_hsize;
    logic [31:0]       ahbls_hwdata;
    logic [31:0]       ahbls_hrdata;
    logic [W_ADDR-1:0] ctrl_addr;
    logic [15:0]       ctrl_dq_out;
    logic [15:0]       ctrl_dq_oe;
    logic [15:0]       ctrl_dq_in;
    logic              ctrl_ce_n;
    logic              ctrl_we_n;
    logic              ctrl_oe_n;
    logic [1:0]        ctrl_byte_n;

    always #5 clk = ~clk;
    assign ahbls_hready = ahbls_hready_resp & ~stall;

    async_sram_ctrl_ahb #(.W_ADDR(W_ADDR), .W_DATA(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .ahbls_hready     (ahbls_hready),
        .ahbls_hready_resp(ahbls_hready_resp),
        .ahbls_hresp      (ahbls_hresp),
        .ahbls_haddr      (ahbls_haddr),
        .ahbls_hwrite     (ahbls_hwrite),
        .ahbls_htrans     (ahbls_htrans),
        .ahbls_hsize      (ahbls_hsize),
        .ahbls_hwdata     (ahbls_hwdata),
        .ahbls_hrdata     (ahbls_hrdata),
        .ctrl_addr        (ctrl_addr),
        .ctrl_dq_out      (ctrl_dq_out),
        .ctrl_dq_oe       (ctrl_dq_oe),
        .ctrl_dq_in       (ctrl_dq_in),
        .ctrl_ce_n        (ctrl_ce_n),
        .ctrl_we_n        (ctrl_we_n),
        .ctrl_oe_n        (ctrl_oe_n),
        .ctrl_byte_n      (ctrl_byte_n)
    );

    int checks = 0;
    int errors = 0;
    int contention = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- PHY pin registers + asynchronous SRAM ----------------
    logic [W_ADDR-1:0] pin_addr;
    logic              pin_ce_n, pin_we_n, pin_oe_n;
    logic [1:0]        pin_byte_n;
    logic [15:0]       sram [int];

    function automatic logic [15:0] sram_rd(input int a);
        return sram.exists(a) ? sram[a] : 16'h0;
    endfunction

    always @(posedge clk) begin
        logic [15:0] h;
        if (!pin_ce_n && !pin_we_n && ctrl_dq_oe == 16'hffff) begin
            h = sram_rd(int'(pin_addr));
            if (!pin_byte_n[0]) h[7:0]  = ctrl_dq_out[7:0];
            if (!pin_byte_n[1]) h[15:8] = ctrl_dq_out[15:8];
            sram[int'(pin_addr)] = h;
        end
        if (rst) begin
            pin_addr <= '0; pin_ce_n <= 1'b1; pin_we_n <= 1'b1; pin_oe_n <= 1'b1; pin_byte_n <= 2'b11;
        end else begin
            pin_addr <= ctrl_addr; pin_ce_n <= ctrl_ce_n; pin_we_n <= ctrl_we_n;
            pin_oe_n <= ctrl_oe_n; pin_byte_n <= ctrl_byte_n;
        end
    end

    initial ctrl_dq_in = 16'h0;
    always @(posedge clk) begin
        #2;
        ctrl_dq_in = (!pin_ce_n && !pin_oe_n) ? sram_rd(int'(pin_addr)) : 16'h0;
    end

    always @(negedge clk) begin
        if (!rst && !pin_oe_n && ctrl_dq_oe != 16'h0) contention++;
    end

    // ---------------- byte-addressed reference memory ----------------
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] rb(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [2:0] sz);
        int b;
        logic [15:0] h;
        b = int'(addr & ADDR_MASK);
        if (sz == 3'd2) begin
            b = b & ~3;
            return {rb(b + 3), rb(b + 2), rb(b + 1), rb(b)};
        end
        b = b & ~1;
        h = {rb(b + 1), rb(b)};
        return {h, h};
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wd);
        int b;
        logic [15:0] lane;
        b = int'(addr & ADDR_MASK);
        if (sz == 3'd2) begin
            b = b & ~3;
            for (int i = 0; i < 4; i++) ref_mem[b + i] = wd[8*i +: 8];
        end else if (sz == 3'd1) begin
            b = b & ~1;
            lane = addr[1] ? wd[31:16] : wd[15:0];
            ref_mem[b] = lane[7:0];
            ref_mem[b + 1] = lane[15:8];
        end else begin
            ref_mem[b] = wd[8*addr[1:0] +: 8];
        end
    endtask

    // ---------------- transaction driver ----------------
    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t txq[$];
    bit   force_b2b;

    function automatic txn_t mk(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.wr = wr; t.size = sz; t.addr = a; t.wdata = d;
        return t;
    endfunction

    task automatic drive_idle();
        ahbls_htrans = 2'b00;
        ahbls_haddr  = $urandom;
        ahbls_hwrite = 1'($urandom);
        ahbls_hsize  = 3'($urandom_range(0, 2));
    endtask

    task automatic check_d1(input txn_t t);
        logic [31:0]       a;
        logic [W_ADDR-1:0] ea;
        logic [1:0]        ebn;
        a   = t.addr & ADDR_MASK;
        ea  = (t.size == 3'd2) ? {a[W_ADDR:2], 1'b0} : a[W_ADDR:1];
        ebn = (t.wr && t.size == 3'd0) ? (a[0] ? 2'b01 : 2'b10) : 2'b00;
        check("d1_pins", {ctrl_addr, ctrl_byte_n, ctrl_ce_n, ctrl_we_n, ctrl_oe_n, ctrl_dq_oe},
              {ea, ebn, 1'b0, ~t.wr, t.wr, 16'h0});
    endtask

    task automatic complete(input txn_t t, input int waits);
        check("waits", 64'(waits), (t.size == 3'd2) ? 64'd2 : 64'd1);
        check("hresp", 64'(ahbls_hresp), 64'd0);
        if (t.wr) begin
            check("wr_tail_dq", {ctrl_dq_oe, ctrl_dq_out},
                  {16'hffff, (t.size == 3'd2 || t.addr[1]) ? t.wdata[31:16] : t.wdata[15:0]});
            ref_write(t.addr, t.size, t.wdata);
        end else begin
            check("rdata", 64'(ahbls_hrdata), 64'(ref_read(t.addr, t.size)));
        end
    endtask

    task automatic run_queue();
        txn_t cur, acc;
        bit   cur_v, acc_v, addr_v;
        int   waits, idx, budget;
        cur_v = 0; acc_v = 0; addr_v = 0; waits = 0; idx = 0; budget = 0;
        while ((idx < txq.size() || addr_v || acc_v || cur_v) && budget < 20000) begin
            @(posedge clk); #1;
            if (acc_v) begin
                cur = acc; cur_v = 1; acc_v = 0; waits = 0; addr_v = 0;
                ahbls_hwdata = cur.wr ? cur.wdata : $urandom;
                check_d1(cur);
            end
            if (!addr_v) begin
                if (idx < txq.size() && (force_b2b || $urandom_range(0, 3) != 0)) begin
                    ahbls_htrans = 2'b10;
                    ahbls_haddr  = txq[idx].addr;
                    ahbls_hwrite = txq[idx].wr;
                    ahbls_hsize  = txq[idx].size;
                    addr_v = 1;
                end else begin
                    drive_idle();
                end
            end
            stall = !cur_v && !force_b2b && ($urandom_range(0, 5) == 0);
            @(negedge clk);
            if (cur_v) begin
                if (ahbls_hready) begin
                    complete(cur, waits);
                    cur_v = 0;
                end else begin
                    waits++;
                end
            end
            if (addr_v && ahbls_hready) begin
                acc = txq[idx]; idx++; acc_v = 1;
            end
            budget++;
        end
        if (budget >= 20000) check("timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        drive_idle();
        stall = 1'b0;
        txq.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ahb"}, {ahbls_hready_resp, ahbls_hresp, ahbls_hrdata}, {1'b1, 1'b0, 32'h0});
        check({tag, "_pins"}, {ctrl_addr, ctrl_dq_out, ctrl_dq_oe, ctrl_ce_n, ctrl_we_n, ctrl_oe_n, ctrl_byte_n},
              {{W_ADDR{1'b0}}, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 2'b11});
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        rst = 1'b1; stall = 1'b0; force_b2b = 1'b1; ahbls_hwdata = '0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst_init");
        rst = 1'b0;

        // Word write abandoned by a two-cycle reset in its first data-phase cycle.
        @(posedge clk); #1;
        ahbls_htrans = 2'b10; ahbls_haddr = 32'h40; ahbls_hwrite = 1'b1; ahbls_hsize = 3'd2;
        @(posedge clk); #1;
        drive_idle();
        ahbls_hwdata = 32'h1234_5678;
        @(negedge clk);
        check("mid_we_n", 64'(ctrl_we_n), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_mid1");
        @(negedge clk);
        check_reset_state("rst_mid2");
        rst = 1'b0;

        // Directed sequence, fully back-to-back.
        txq.push_back(mk(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF));
        txq.push_back(mk(1'b0, 3'd2, 32'h0000_0010, 32'h0));
        txq.push_back(mk(1'b1, 3'd0, 32'h0000_0013, 32'hAB00_0000));
        txq.push_back(mk(1'b0, 3'd1, 32'h0000_0012, 32'h0));
        txq.push_back(mk(1'b1, 3'd2, 32'h0000_0020, 32'hCAFE_F00D));
        txq.push_back(mk(1'b0, 3'd2, 32'h0000_0020, 32'h0));
        txq.push_back(mk(1'b1, 3'd1, 32'h0003_FFFE, 32'h5A5A_A5A5));
        txq.push_back(mk(1'b0, 3'd1, 32'h0003_FFFE, 32'h0));
        txq.push_back(mk(1'b0, 3'd2, 32'h0000_0000, 32'h0));
        txq.push_back(mk(1'b1, 3'd0, 32'h0007_FFFF, 32'h7700_0000));
        txq.push_back(mk(1'b0, 3'd0, 32'h0007_FFFF, 32'h0));
        run_queue();
        check("sram9", 64'(sram_rd(9)), 64'h0000_ABAD);

        // Random traffic clustered at the bottom and top of the address space.
        force_b2b = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sz = 3'($urandom_range(0, 2));
            a  = ($urandom_range(0, 1) ? 32'h0 : 32'h0007_FF80) | 32'($urandom_range(0, 127));
            a  = a | ($urandom & ~ADDR_MASK);
            if (sz == 3'd2) a[1:0] = 2'b00;
            if (sz == 3'd1) a[0] = 1'b0;
            txq.push_back(mk(1'($urandom), sz, a, $urandom));
        end
        run_queue();

        foreach (ref_mem[k]) begin
            logic [15:0] h;
            h = sram_rd(k >>> 1);
            check("mem_byte", 64'(k[0] ? h[15:8] : h[7:0]), 64'(ref_mem[k]));
        end
        foreach (sram[h]) begin
            check("mem_half", 64'(sram[h]), 64'({rb(2 * h + 1), rb(2 * h)}));
        end
        check("dq_contention", 64'(contention), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
